// File: rtl/perf_monitor.sv
// perf_monitor: multi-channel performance counter block.
//   A cycle counter and N_EVT event counters run while the FSM is in RUN
//   with start_i high. They freeze in IDLE/HOLD/DONE. The block stops
//   automatically after CYCLE_LIMIT counting edges; CYCLE_LIMIT=0 disables
//   the stop. Every counter saturates at all-ones. An event arriving at
//   saturation sets a sticky per-channel overflow flag.
//
// Ports:
//   clk_i      single clock, rising edge
//   rst_i      synchronous reset, active low (overrides everything)
//   start_i    level enable: 1 = count, 0 = pause
//   clear_i    synchronous clear of counters/flags, FSM back to IDLE
//   event_i    per-channel event strobes, one count per high cycle
//   sel_i      channel selected for readout
//   rd_data_o  registered counter[sel_i] (pre-edge value), 0 if sel_i >= N_EVT
//   cycle_o    cycle counter register
//   ovf_o      sticky per-channel saturation flags
//   done_o     high while in DONE
//   state_o    IDLE=00, RUN=01, HOLD=10, DONE=11

// One saturating event counter with its sticky overflow flag.
module perf_evt_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            if (&cnt_q) ovf_d = 1'b1;
            else        cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;
endmodule

module perf_monitor #(
    parameter int CNT_W       = 32,
    parameter int N_EVT       = 4,
    parameter int SEL_W       = 2,
    parameter int CYCLE_LIMIT = 30
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic [N_EVT-1:0] event_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [CNT_W-1:0] rd_data_o,
    output logic [CNT_W-1:0] cycle_o,
    output logic [N_EVT-1:0] ovf_o,
    output logic             done_o,
    output logic [1:0]       state_o
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CYCLE_LIMIT);

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cyc_q, cyc_d;
    logic [CNT_W-1:0]              rd_q, rd_d;
    logic [N_EVT-1:0][CNT_W-1:0]   evt_cnt;
    logic                          cnt_en;

    // Counting happens only on RUN edges that stay in (or finish) RUN;
    // the edge entering RUN and the edge leaving to HOLD do not count.
    assign cnt_en = (state_q == S_RUN) && start_i && !clear_i;

    // Saturating cycle counter value after this edge's increment.
    always_comb begin
        cyc_d = cyc_q;
        if (clear_i)     cyc_d = '0;
        else if (cnt_en && !(&cyc_q)) cyc_d = cyc_q + CNT_W'(1);
    end

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (!rst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state. The limit check uses the post-increment value so the
    // edge that reaches CYCLE_LIMIT is itself a counting edge.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) state_d = S_RUN;
                S_RUN: begin
                    if (!start_i)
                        state_d = S_HOLD;
                    else if ((CYCLE_LIMIT != 0) && (cyc_d == LIMIT))
                        state_d = S_DONE;
                end
                S_HOLD: if (start_i) state_d = S_RUN;
                default: state_d = S_DONE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        done_o  = (state_q == S_DONE);
        state_o = state_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) cyc_q <= '0;
        else        cyc_q <= cyc_d;
    end

    // Per-channel counters, all counted concurrently.
    for (genvar k = 0; k < N_EVT; k++) begin : g_evt
        perf_evt_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clear_i),
            .inc_i (cnt_en & event_i[k]),
            .cnt_o (evt_cnt[k]),
            .ovf_o (ovf_o[k])
        );
    end

    // Readout mux; unmatched selects (sel_i >= N_EVT) yield zero.
    always_comb begin
        rd_d = '0;
        for (int k = 0; k < N_EVT; k++)
            if (sel_i == SEL_W'(k)) rd_d = evt_cnt[k];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) rd_q <= '0;
        else        rd_q <= rd_d;
    end

    assign rd_data_o = rd_q;
    assign cycle_o   = cyc_q;
endmodule

// File: tb/tb_perf_monitor.sv
// Bench for perf_monitor: three instances (defaults, 4-bit/no-limit,
// 3-channel) share one stimulus stream and are checked every cycle
// against a behavioural model, plus literal checkpoints.
module tb_perf_monitor;
    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0, start = 1'b0, clear = 1'b0;
    logic [3:0] ev = '0;
    logic [1:0] sel = '0;

    logic [31:0] a_rd, a_cyc;  logic [3:0] a_ovf; logic a_done; logic [1:0] a_st;
    logic [3:0]  b_rd, b_cyc;  logic [3:0] b_ovf; logic b_done; logic [1:0] b_st;
    logic [31:0] c_rd, c_cyc;  logic [2:0] c_ovf; logic c_done; logic [1:0] c_st;

    perf_monitor #(.CNT_W(32), .N_EVT(4), .SEL_W(2), .CYCLE_LIMIT(30)) u_a (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .clear_i(clear),
        .event_i(ev), .sel_i(sel), .rd_data_o(a_rd), .cycle_o(a_cyc),
        .ovf_o(a_ovf), .done_o(a_done), .state_o(a_st));

    perf_monitor #(.CNT_W(4), .N_EVT(4), .SEL_W(2), .CYCLE_LIMIT(0)) u_b (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .clear_i(clear),
        .event_i(ev), .sel_i(sel), .rd_data_o(b_rd), .cycle_o(b_cyc),
        .ovf_o(b_ovf), .done_o(b_done), .state_o(b_st));

    perf_monitor #(.CNT_W(32), .N_EVT(3), .SEL_W(2), .CYCLE_LIMIT(30)) u_c (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .clear_i(clear),
        .event_i(ev[2:0]), .sel_i(sel), .rd_data_o(c_rd), .cycle_o(c_cyc),
        .ovf_o(c_ovf), .done_o(c_done), .state_o(c_st));

    int n_vec = 0, n_err = 0;

    task automatic chk(string nm, longint unsigned act, longint unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int IDLE = 0, RUN = 1, HOLD = 2, DONE = 3;
    int              CW[3]  = '{32, 4, 32};
    int              NE[3]  = '{4, 4, 3};
    int              LIM[3] = '{30, 0, 30};
    int              m_st[3];
    longint unsigned m_cyc[3], m_rd[3];
    longint unsigned m_cnt[3][4];
    bit              m_ovf[3][4];
    bit              primed = 1'b0;

    function automatic longint unsigned m_ovf_vec(int i);
        longint unsigned v = 0;
        for (int k = 0; k < NE[i]; k++) if (m_ovf[i][k]) v += (64'd1 << k);
        return v;
    endfunction

    // Advance instance i by one edge using the inputs presented for it.
    task automatic mdl_step(int i);
        longint unsigned mx  = (64'd1 << CW[i]) - 1;
        longint unsigned rdn = (int'(sel) < NE[i]) ? m_cnt[i][sel] : 0;
        if (!rst_n) begin
            m_st[i] = IDLE; m_cyc[i] = 0; m_rd[i] = 0;
            for (int k = 0; k < 4; k++) begin m_cnt[i][k] = 0; m_ovf[i][k] = 0; end
        end else begin
            m_rd[i] = rdn;
            if (clear) begin
                m_st[i] = IDLE; m_cyc[i] = 0;
                for (int k = 0; k < 4; k++) begin m_cnt[i][k] = 0; m_ovf[i][k] = 0; end
            end else if (m_st[i] == IDLE || m_st[i] == HOLD) begin
                if (start) m_st[i] = RUN;
            end else if (m_st[i] == RUN) begin
                if (!start) m_st[i] = HOLD;
                else begin
                    if (m_cyc[i] < mx) m_cyc[i]++;
                    for (int k = 0; k < NE[i]; k++)
                        if (ev[k]) begin
                            if (m_cnt[i][k] == mx) m_ovf[i][k] = 1;
                            else m_cnt[i][k]++;
                        end
                    if (LIM[i] != 0 && m_cyc[i] == longint'(LIM[i])) m_st[i] = DONE;
                end
            end
        end
    endtask

    // Inputs change only 2 time units after a rising edge, so at the falling
    // edge they are exactly what the next rising edge will sample.
    always @(negedge clk) begin
        if (primed) begin
            chk("a.state", a_st, m_st[0]);   chk("a.cycle", a_cyc, m_cyc[0]);
            chk("a.ovf", a_ovf, m_ovf_vec(0)); chk("a.done", a_done, m_st[0] == DONE);
            chk("a.rd", a_rd, m_rd[0]);
            chk("b.state", b_st, m_st[1]);   chk("b.cycle", b_cyc, m_cyc[1]);
            chk("b.ovf", b_ovf, m_ovf_vec(1)); chk("b.done", b_done, m_st[1] == DONE);
            chk("b.rd", b_rd, m_rd[1]);
            chk("c.state", c_st, m_st[2]);   chk("c.cycle", c_cyc, m_cyc[2]);
            chk("c.ovf", c_ovf, m_ovf_vec(2)); chk("c.done", c_done, m_st[2] == DONE);
            chk("c.rd", c_rd, m_rd[2]);
        end
        for (int i = 0; i < 3; i++) mdl_step(i);
        primed = 1'b1;
    end

    task automatic step_n(int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    // ---------------- stimulus + literal checkpoints ----------------
    initial begin
        step_n(2);
        chk("rst.state", a_st, 0); chk("rst.cycle", a_cyc, 0);
        chk("rst.rd", a_rd, 0);    chk("rst.ovf", a_ovf, 0);
        rst_n = 1'b1;
        step_n(1);

        // Auto-stop after 30 counting edges; ch1 every 3rd counting edge.
        start = 1'b1;
        for (int j = 0; j < 40; j++) begin
            ev = {2'b00, (j % 3 == 0), 1'b1};
            step_n(1);
        end
        chk("lim.cycle", a_cyc, 30); chk("lim.done", a_done, 1);
        chk("lim.state", a_st, 3);
        chk("mdl.ch0", m_cnt[0][0], 30); chk("mdl.ch1", m_cnt[0][1], 10);
        chk("sat.b.cycle", b_cyc, 15); chk("sat.b.state", b_st, 1);
        chk("sat.b.ovf0", b_ovf[0], 1);

        // Readout sweep while DONE ignores further events.
        ev = 4'b1111;
        sel = 2'd0; step_n(1); chk("sel0.rd", a_rd, 30);
        sel = 2'd1; step_n(1); chk("sel1.rd", a_rd, 10);
        sel = 2'd2; step_n(1); chk("sel2.rd", a_rd, 0);
        sel = 2'd3; step_n(1); chk("sel3.rd", a_rd, 0); chk("c.sel3.rd", c_rd, 0);

        // Clear beats start/events on a RUN edge (instance b is in RUN).
        clear = 1'b1; step_n(1); clear = 1'b0; start = 1'b0;
        chk("clr.b.state", b_st, 0); chk("clr.b.cycle", b_cyc, 0);
        chk("clr.b.ovf", b_ovf, 0);  chk("clr.a.state", a_st, 0);
        step_n(1);

        // 4-bit counter saturation on channel 2 with no cycle limit.
        ev = 4'b0100; start = 1'b1;
        step_n(21);
        chk("sat.b.cyc15", b_cyc, 15); chk("sat.b.ovf", b_ovf, 4'b0100);
        chk("sat.b.run", b_st, 1);
        sel = 2'd2; step_n(1); chk("sat.b.rd", b_rd, 15);
        clear = 1'b1; start = 1'b0; step_n(1); clear = 1'b0;

        // Pause/resume: HOLD cycles are not counted.
        ev = 4'b1111; start = 1'b1; sel = 2'd3;
        step_n(6);
        start = 1'b0; step_n(4);
        chk("hold.state", a_st, 2); chk("hold.cycle", a_cyc, 5);
        chk("hold.rd3", a_rd, 5);
        start = 1'b1; step_n(4);
        chk("resume.cycle", a_cyc, 8);
        clear = 1'b1; step_n(1); clear = 1'b0;
        chk("clr.a.cycle", a_cyc, 0); chk("clr.a.idle", a_st, 0);
        chk("clr.a.ovf", a_ovf, 0);

        // Reset mid-RUN at cycle 12, then a full fresh run.
        ev = 4'b0001; start = 1'b1;
        step_n(13); chk("pre.rst.cycle", a_cyc, 12);
        rst_n = 1'b0; step_n(1); rst_n = 1'b1;
        chk("mrst.state", a_st, 0); chk("mrst.cycle", a_cyc, 0);
        chk("mrst.rd", a_rd, 0);    chk("mrst.ovf", a_ovf, 0);
        chk("mrst.done", a_done, 0);
        step_n(31);
        chk("rerun.cycle", a_cyc, 30); chk("rerun.done", a_done, 1);

        // Randomized traffic.
        for (int j = 0; j < 3000; j++) begin
            start = ($urandom % 8) != 0;
            clear = ($urandom % 64) == 0;
            rst_n = ($urandom % 128) != 0;
            ev    = 4'($urandom);
            sel   = 2'($urandom);
            step_n(1);
        end
        rst_n = 1'b1; clear = 1'b0;
        step_n(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 Parameter CNT_W, default 32, width of every counter and of rd_data_o/cycle_o.
REQ-002 Parameter N_EVT, default 4, number of independent event channels (1..16).
REQ-003 Parameter SEL_W, default 2, width of sel_i; SHALL satisfy 2**SEL_W >= N_EVT.
REQ-004 Parameter CYCLE_LIMIT, default 30, RUN cycles counted before auto-stop; 0 = no limit.
REQ-005 clk_i  input  1  single clock; all state updates on rising edge.
REQ-006 rst_i  input  1  synchronous, active-low reset.
REQ-007 start_i  input  1  level enable; 1 = count, 0 = pause.
REQ-008 clear_i  input  1  synchronous clear of all counters and flags.
REQ-009 event_i  input  N_EVT  per-channel event strobes (e.g. stall, flush, retire), one count per high cycle.
REQ-010 sel_i  input  SEL_W  event channel selected for readout.
REQ-011 rd_data_o  output  CNT_W  registered value of event counter sel_i.
REQ-012 cycle_o  output  CNT_W  current cycle counter value (direct register output).
REQ-013 ovf_o  output  N_EVT  sticky per-channel saturation flags.
REQ-014 done_o  output  1  high while in DONE.
REQ-015 state_o  output  2  FSM state: IDLE=00, RUN=01, HOLD=10, DONE=11.

Function
REQ-016 FSM states IDLE, RUN, HOLD, DONE; one transition max per edge.
REQ-017 IDLE: counters frozen; start_i=1 -> RUN; no counting on the edge leaving IDLE.
REQ-018 RUN, start_i=1: cycle counter +1, each event counter k +event_i[k], same edge.
REQ-019 RUN, start_i=0: -> HOLD; no counter changes on that edge.
REQ-020 HOLD: counters frozen; start_i=1 -> RUN, no counting on that edge.
REQ-021 RUN edge where cycle counter becomes CYCLE_LIMIT (CYCLE_LIMIT!=0): counting on that edge still performed, state -> DONE; exactly CYCLE_LIMIT counting edges total.
REQ-022 DONE: all counters frozen, done_o=1, start_i and event_i ignored; exit only via clear_i or reset.
REQ-023 clear_i=1 (any state): all counters and ovf_o to 0, state -> IDLE; clear_i has priority over start_i and event_i on the same edge.
REQ-024 Event counters saturate at 2**CNT_W-1; an event arriving at saturation leaves value unchanged and sets ovf_o[k]; ovf_o[k] stays 1 until clear_i or reset.
REQ-025 Cycle counter saturates at 2**CNT_W-1 (relevant when CYCLE_LIMIT=0); state stays RUN.
REQ-026 rd_data_o = event counter[sel_i] as sampled at previous edge (1-cycle latency, reflects pre-edge counter value); sel_i >= N_EVT -> rd_data_o = 0 next cycle.
REQ-027 All event channels counted concurrently; simultaneous events on every channel each increment their own counter.

Reset
REQ-028 rst_i=0 at an edge: state IDLE, all counters 0, rd_data_o 0, ovf_o 0, done_o 0; overrides clear_i, start_i, event_i.
REQ-029 Reset asserted mid-RUN discards all counts; counting resumes only after rst_i=1 and start_i=1 via IDLE->RUN.

Verification
REQ-030 Defaults; start_i=1 held, event_i[0]=1 every cycle, event_i[1]=1 every 3rd RUN cycle -> DONE after 30 counting edges, cycle_o=30, ch0=30, ch1=10, done_o=1.
REQ-031 start_i=1 for 5 RUN edges, 0 for 4 cycles, 1 again, event_i=4'b1111 throughout -> all counters exclude HOLD cycles, ch0..ch3=cycle_o at every point.
REQ-032 CNT_W=4, CYCLE_LIMIT=0, event_i[2]=1 for 20 RUN edges -> ch2=15, ovf_o=4'b0100, cycle_o=15, state_o stays RUN.
REQ-033 clear_i=1 and event_i=4'b1111 on the same RUN edge -> all counters 0, ovf_o 0, state_o=IDLE next cycle.
REQ-034 rst_i=0 for one edge at cycle_o=12 -> all outputs 0, state IDLE; release with start_i=1 -> count restarts from 0 and DONE after 30 further counting edges.
REQ-035 sel_i sweeps 0..3 after DONE in REQ-030 -> rd_data_o shows 30, 10, 0, 0 each one cycle after sel_i change; N_EVT=3, sel_i=3 -> rd_data_o=0.
